// File: rtl/cfg_axi_master.sv
// cfg_axi_master
//   Single-outstanding AXI4-Lite master. It executes the register access at the
//   head of the config CDC FIFO (axi_rd_go / axi_wr_go levels), runs it on the
//   AXI4-Lite bus, and pulses axi_rd_done / axi_wr_done once to dequeue the FIFO.
//   Error responses and bus hangs (TIMEOUT_CYCLES) are reported on axi_error.
// Ports
//   axi_clk, rst             clock, synchronous active-high reset
//   axi_rdwr_addr/wr_data    request address / write data at FIFO head
//   axi_rd_go/axi_wr_go      request levels, sampled only in IDLE
//   axi_rd_done/axi_wr_done  1-cycle completion pulses (FIFO dequeue)
//   axi_rd_data              last read result (0xdeadbeef on error/timeout)
//   axi_error                1-cycle pulse alongside a done pulse on failure
//   m_axi_*                  AXI4-Lite master channels AW, W, B, AR, R
module cfg_axi_master #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        axi_clk,
    input  logic        rst,
    input  logic [31:0] axi_rdwr_addr,
    input  logic [31:0] axi_wr_data,
    input  logic        axi_rd_go,
    input  logic        axi_wr_go,
    output logic        axi_rd_done,
    output logic        axi_wr_done,
    output logic [31:0] axi_rd_data,
    output logic        axi_error,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_GAP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_awaddr, w_awaddr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_araddr, w_araddr_nxt;
    logic [31:0] r_rd_data, w_rd_data_nxt;
    logic        r_awvalid, w_awvalid_nxt;
    logic        r_wvalid, w_wvalid_nxt;
    logic        r_bready, w_bready_nxt;
    logic        r_arvalid, w_arvalid_nxt;
    logic        r_rready, w_rready_nxt;
    logic        r_wr_done, w_wr_done_nxt;
    logic        r_rd_done, w_rd_done_nxt;
    logic        r_error, w_error_nxt;
    logic        w_timeout;
    logic        w_aw_ok;
    logic        w_w_ok;

    assign w_timeout = (r_cnt == TO_LAST);
    // A write channel is finished once its valid has dropped or it handshakes now.
    assign w_aw_ok   = !r_awvalid || m_axi_awready;
    assign w_w_ok    = !r_wvalid  || m_axi_wready;

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_araddr  <= '0;
            r_rd_data <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_araddr  <= w_araddr_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_state == S_IDLE || r_state == S_GAP) ? '0 : r_cnt + 16'd1;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_araddr_nxt  = r_araddr;
        w_rd_data_nxt = r_rd_data;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_wr_done_nxt = 1'b0;
        w_rd_done_nxt = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (axi_wr_go) begin
                    w_awaddr_nxt  = axi_rdwr_addr;
                    w_wdata_nxt   = axi_wr_data;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_state_nxt   = S_WR;
                end else if (axi_rd_go) begin
                    w_araddr_nxt  = axi_rdwr_addr;
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = S_RD_ADDR;
                end
            end
            S_WR: begin
                if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
                if (r_wvalid && m_axi_wready)   w_wvalid_nxt  = 1'b0;
                // A handshake completing on the timeout edge still counts.
                if (w_aw_ok && w_w_ok) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WR_RESP;
                end else if (w_timeout) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_wr_done_nxt = 1'b1;
                    w_error_nxt   = 1'b1;
                    w_state_nxt   = S_GAP;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    w_bready_nxt  = 1'b0;
                    w_wr_done_nxt = 1'b1;
                    w_error_nxt   = (m_axi_bresp != 2'b00);
                    w_state_nxt   = S_GAP;
                end else if (w_timeout) begin
                    w_bready_nxt  = 1'b0;
                    w_wr_done_nxt = 1'b1;
                    w_error_nxt   = 1'b1;
                    w_state_nxt   = S_GAP;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_DATA;
                end else if (w_timeout) begin
                    w_arvalid_nxt = 1'b0;
                    w_rd_done_nxt = 1'b1;
                    w_error_nxt   = 1'b1;
                    w_rd_data_nxt = ERR_DATA;
                    w_state_nxt   = S_GAP;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    w_rready_nxt  = 1'b0;
                    w_rd_done_nxt = 1'b1;
                    w_error_nxt   = (m_axi_rresp != 2'b00);
                    w_rd_data_nxt = (m_axi_rresp != 2'b00) ? ERR_DATA : m_axi_rdata;
                    w_state_nxt   = S_GAP;
                end else if (w_timeout) begin
                    w_rready_nxt  = 1'b0;
                    w_rd_done_nxt = 1'b1;
                    w_error_nxt   = 1'b1;
                    w_rd_data_nxt = ERR_DATA;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign axi_rd_done   = r_rd_done;
    assign axi_wr_done   = r_wr_done;
    assign axi_rd_data   = r_rd_data;
    assign axi_error     = r_error;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_cfg_axi_master.sv
// tb_cfg_axi_master
//   Bench for cfg_axi_master: a reactive AXI4-Lite slave with per-request
//   channel delays, a request table, and a scoreboard of expected completions.
module tb_cfg_axi_master;

    localparam int unsigned TO = 16;

    logic        axi_clk = 1'b0;
    logic        rst;
    logic [31:0] axi_rdwr_addr, axi_wr_data;
    logic        axi_rd_go, axi_wr_go;
    logic        axi_rd_done, axi_wr_done, axi_error;
    logic [31:0] axi_rd_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    cfg_axi_master #(.TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(axi_clk), .rst(rst),
        .axi_rdwr_addr(axi_rdwr_addr), .axi_wr_data(axi_wr_data),
        .axi_rd_go(axi_rd_go), .axi_wr_go(axi_wr_go),
        .axi_rd_done(axi_rd_done), .axi_wr_done(axi_wr_done),
        .axi_rd_data(axi_rd_data), .axi_error(axi_error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 axi_clk = ~axi_clk;

    int unsigned cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        hang;
        logic        exp_err;
        logic [31:0] exp_rd;
        int unsigned exp_lat;
    } vec_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr, data, rd;
        logic        err;
        int unsigned lat, aw_hi, w_hi, ar_hi, t0;
        logic        chk_chan;
    } sb_t;

    sb_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    int unsigned n_done   = 0;

    // slave configuration for the current request
    int unsigned s_aw_dly, s_w_dly, s_b_dly, s_ar_dly, s_r_dly;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic        s_hang = 1'b0;
    logic        force_rv = 1'b0;

    // slave captures
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    int unsigned cap_aw_hi, cap_w_hi, cap_ar_hi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                                input int unsigned aw, input int unsigned w, input int unsigned b,
                                input int unsigned ar, input int unsigned r, input logic [1:0] resp,
                                input logic [31:0] rdata, input logic hang, input logic exp_err,
                                input logic [31:0] exp_rd, input int unsigned exp_lat);
        vec_t v;
        v.is_wr = is_wr; v.addr = addr; v.data = data;
        v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r;
        v.resp = resp; v.rdata = rdata; v.hang = hang;
        v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Present a request at the FIFO head and queue its expected completion.
    task automatic present(input vec_t v, input int unsigned extra);
        sb_t e;
        s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_b_dly = v.b_dly;
        s_ar_dly = v.ar_dly; s_r_dly = v.r_dly; s_resp = v.resp;
        s_rdata = v.rdata; s_hang = v.hang;
        axi_rdwr_addr = v.addr;
        axi_wr_data   = v.data;
        axi_wr_go     = v.is_wr;
        axi_rd_go     = !v.is_wr;
        e.is_wr = v.is_wr; e.addr = v.addr; e.data = v.data; e.rd = v.exp_rd;
        e.err = v.exp_err; e.lat = v.exp_lat + extra;
        e.aw_hi = v.aw_dly + 1; e.w_hi = v.w_dly + 1; e.ar_hi = v.ar_dly + 1;
        e.t0 = cyc; e.chk_chan = !v.hang;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        do begin
            @(negedge axi_clk);
            n++;
        end while (!(axi_wr_done || axi_rd_done) && n < 60);
        if (!(axi_wr_done || axi_rd_done)) chk(name, 32'(axi_wr_done | axi_rd_done), 32'd1);
    endtask

    task automatic go_idle();
        axi_wr_go = 1'b0;
        axi_rd_go = 1'b0;
    endtask

    // Reactive slave: drives at negedge from the master outputs of that cycle.
    initial begin : slave
        int unsigned aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
        logic aw_fire = 0, w_fire = 0, ar_fire = 0, b_fire = 0, r_fire = 0, r_forced = 0;
        logic aw_seen = 0, w_seen = 0, ar_seen = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        forever begin
            @(negedge axi_clk);
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0; r_forced = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0;
            end else begin
                if (aw_fire) begin
                    m_axi_awready = 0; aw_fire = 0; aw_seen = 1; aw_cnt = 0;
                end else if (m_axi_awvalid) begin
                    if (!s_hang && aw_cnt >= s_aw_dly) begin
                        m_axi_awready = 1; aw_fire = 1;
                        cap_awaddr = m_axi_awaddr; cap_aw_hi = aw_cnt + 1;
                    end
                    aw_cnt++;
                end else aw_cnt = 0;

                if (w_fire) begin
                    m_axi_wready = 0; w_fire = 0; w_seen = 1; w_cnt = 0;
                end else if (m_axi_wvalid) begin
                    if (!s_hang && w_cnt >= s_w_dly) begin
                        m_axi_wready = 1; w_fire = 1;
                        cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; cap_w_hi = w_cnt + 1;
                    end
                    w_cnt++;
                end else w_cnt = 0;

                if (b_fire) begin
                    m_axi_bvalid = 0; b_fire = 0;
                end else if (aw_seen && w_seen && m_axi_bready) begin
                    if (b_cnt >= s_b_dly) begin
                        m_axi_bvalid = 1; m_axi_bresp = s_resp; b_fire = 1;
                        aw_seen = 0; w_seen = 0; b_cnt = 0;
                    end else b_cnt++;
                end

                if (ar_fire) begin
                    m_axi_arready = 0; ar_fire = 0; ar_seen = 1; ar_cnt = 0;
                end else if (m_axi_arvalid) begin
                    if (!s_hang && ar_cnt >= s_ar_dly) begin
                        m_axi_arready = 1; ar_fire = 1;
                        cap_araddr = m_axi_araddr; cap_ar_hi = ar_cnt + 1;
                    end
                    ar_cnt++;
                end else ar_cnt = 0;

                if (force_rv) begin
                    m_axi_rvalid = 1; m_axi_rdata = 32'h7777_7777; m_axi_rresp = 0; r_forced = 1;
                end else if (r_forced) begin
                    m_axi_rvalid = 0; r_forced = 0;
                end else if (r_fire) begin
                    m_axi_rvalid = 0; r_fire = 0;
                end else if (ar_seen && m_axi_rready) begin
                    if (r_cnt >= s_r_dly) begin
                        m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = s_resp; r_fire = 1;
                        ar_seen = 0; r_cnt = 0;
                    end else r_cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial begin : monitor
        sb_t e;
        logic prev_done = 1'b0;
        forever begin
            @(negedge axi_clk);
            if (!rst) begin
                chk("dual_done", 32'(axi_wr_done & axi_rd_done), 32'd0);
                if (prev_done) chk("gap_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
                if (axi_wr_done || axi_rd_done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        n_checks++; n_errs++;
                        $display("FAIL unexpected_done wr=%b rd=%b required=none (t=%0t)",
                                 axi_wr_done, axi_rd_done, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("done_type", 32'(axi_wr_done), 32'(e.is_wr));
                        chk("latency", cyc - e.t0, e.lat);
                        chk("error", 32'(axi_error), 32'(e.err));
                        chk("idle_outs", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                              m_axi_arvalid, m_axi_rready}), 32'd0);
                        if (!e.is_wr) chk("rd_data", axi_rd_data, e.rd);
                        if (e.chk_chan && e.is_wr) begin
                            chk("awaddr", cap_awaddr, e.addr);
                            chk("wdata", cap_wdata, e.data);
                            chk("wstrb", 32'(cap_wstrb), 32'hF);
                            chk("awvalid_cycles", cap_aw_hi, e.aw_hi);
                            chk("wvalid_cycles", cap_w_hi, e.w_hi);
                        end
                        if (e.chk_chan && !e.is_wr) begin
                            chk("araddr", cap_araddr, e.addr);
                            chk("arvalid_cycles", cap_ar_hi, e.ar_hi);
                        end
                    end
                end else begin
                    chk("error_no_done", 32'(axi_error), 32'd0);
                end
                prev_done = axi_wr_done | axi_rd_done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[8];
        vec_t bb[3];
        vec_t v;
        int unsigned nd;
        int unsigned n;

        //             wr  addr          data          aw w b ar r resp  rdata         hang err exp_rd        lat
        tbl[0] = mk(1, 32'h4000_0010, 32'h1234_5678, 0, 0, 0, 0, 0, 2'd0, 32'h0,         0, 0, 32'h0,         3);
        tbl[1] = mk(0, 32'h4000_0020, 32'h0,         0, 0, 0, 4, 0, 2'd0, 32'hA5A5_0001, 0, 0, 32'hA5A5_0001, 7);
        tbl[2] = mk(1, 32'h4000_0030, 32'hCAFE_0003, 3, 0, 0, 0, 0, 2'd2, 32'h0,         0, 1, 32'h0,         6);
        tbl[3] = mk(0, 32'h4000_0040, 32'h0,         0, 0, 0, 0, 2, 2'd2, 32'h1111_2222, 0, 1, 32'hdeadbeef, 5);
        tbl[4] = mk(1, 32'h4000_0050, 32'h0F0F_0F0F, 0, 2, 3, 0, 0, 2'd1, 32'h0,         0, 1, 32'h0,         8);
        tbl[5] = mk(0, 32'h4000_0060, 32'h0,         0, 0, 0, 1, 1, 2'd0, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 5);
        tbl[6] = mk(0, 32'h4000_0070, 32'h0,         0, 0, 0, 0, 0, 2'd0, 32'h0,         1, 1, 32'hdeadbeef, TO + 1);
        tbl[7] = mk(1, 32'h4000_0080, 32'h5A5A_5A5A, 0, 0, 0, 0, 0, 2'd0, 32'h0,         1, 1, 32'h0,         TO + 1);

        bb[0] = mk(1, 32'h4000_0100, 32'hAAAA_0001, 0, 0, 0, 0, 0, 2'd0, 32'h0,         0, 0, 32'h0,         3);
        bb[1] = mk(0, 32'h4000_0104, 32'h0,         0, 0, 0, 0, 0, 2'd0, 32'h5555_0002, 0, 0, 32'h5555_0002, 3);
        bb[2] = mk(1, 32'h4000_0108, 32'hAAAA_0003, 0, 0, 0, 0, 0, 2'd0, 32'h0,         0, 0, 32'h0,         3);

        rst = 1'b1;
        axi_rdwr_addr = '0;
        axi_wr_data = '0;
        go_idle();
        repeat (3) @(negedge axi_clk);
        chk("rst_done", 32'({axi_wr_done, axi_rd_done, axi_error}), 32'd0);
        chk("rst_rd_data", axi_rd_data, 32'd0);
        chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            present(tbl[i], 0);
            wait_done("done_timeout");
            go_idle();
            if (tbl[i].hang && !tbl[i].is_wr) begin
                // A response arriving after the timeout must be ignored.
                nd = n_done;
                s_hang = 1'b0;
                force_rv = 1'b1;
                repeat (3) @(negedge axi_clk);
                force_rv = 1'b0;
                repeat (3) @(negedge axi_clk);
                chk("late_rvalid_rd_data", axi_rd_data, 32'hdeadbeef);
                chk("late_rvalid_done", n_done, nd);
            end
            repeat (2) @(negedge axi_clk);
        end
        s_hang = 1'b0;

        // Back-to-back FIFO: the next head appears as soon as the done dequeues.
        nd = n_done;
        present(bb[0], 0);
        wait_done("b2b_done0");
        present(bb[1], 1);
        wait_done("b2b_done1");
        present(bb[2], 1);
        wait_done("b2b_done2");
        go_idle();
        repeat (3) @(negedge axi_clk);
        chk("b2b_done_count", n_done - nd, 32'd3);

        // Reset while waiting for the write response.
        v = mk(1, 32'h4000_0200, 32'hBEEF_0200, 0, 0, 6, 0, 0, 2'd0, 32'h0, 0, 0, 32'h0, 9);
        present(v, 0);
        n = 0;
        do begin
            @(negedge axi_clk);
            n++;
        end while (!m_axi_bready && n < 20);
        chk("rst_test_bready", 32'(m_axi_bready), 32'd1);
        nd = n_done;
        rst = 1'b1;
        go_idle();
        sb.delete();
        @(negedge axi_clk);
        chk("midrst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
        chk("midrst_pulses", 32'({axi_wr_done, axi_rd_done, axi_error}), 32'd0);
        chk("midrst_rd_data", axi_rd_data, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge axi_clk);
        chk("midrst_no_done", n_done, nd);
        v = mk(0, 32'h4000_0300, 32'h0, 0, 0, 0, 0, 0, 2'd0, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF, 3);
        present(v, 0);
        wait_done("post_rst_done");
        go_idle();
        repeat (3) @(negedge axi_clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
